// File: rtl/bp_pkg.sv
// Shared types for the gshare/BTB branch predictor: 2-bit counters,
// BTB entry layout and the init/run state of the PHT sweep.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    // Default-width view of one BTB entry, matching the predictor defaults.
    localparam int BTB_TAG_W = 8;
    localparam int BTB_XLEN  = 32;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_XLEN-1:0]  target;
    } btb_entry_t;

    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        ctr_t n;
        n = c;
        unique case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port,
// one synchronous write port, valid bits cleared by synchronous reset.
module bp_btb #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [XLEN-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target
);
    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [XLEN-1:0]    targets [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/target storage needs no reset; a cleared valid bit masks it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
        end
    end

    assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_target = targets[rd_idx];

endmodule

// File: rtl/bp_gshare_btb.sv
// Fetch-stage gshare direction predictor with tagged BTB, speculative global
// history with mispredict repair, and EX-stage redirect generation.
module bp_gshare_btb
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PHT_IDX_W = 12,
    parameter int GHR_W     = 10,
    parameter int BTB_IDX_W = 6,
    parameter int TAG_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             f_valid,
    input  logic             f_stall,
    input  logic [XLEN-1:0]  f_pc,
    input  logic             f_is_branch,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    input  logic [GHR_W-1:0] ex_ghr,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc
);
    localparam int PHT_N = 1 << PHT_IDX_W;

    bp_state_t              state;
    logic [PHT_IDX_W-1:0]   sweep_idx;
    logic [GHR_W-1:0]       ghr;
    ctr_t                   pht [PHT_N];

    logic                   run;
    logic [PHT_IDX_W-1:0]   f_idx;
    logic [PHT_IDX_W-1:0]   ex_idx;
    ctr_t                   f_ctr;
    logic                   btb_hit;
    logic [XLEN-1:0]        btb_target;
    logic                   unused_bits;

    assign run    = (state == RUN);
    assign f_idx  = f_pc[2 +: PHT_IDX_W] ^ PHT_IDX_W'(ghr);
    assign ex_idx = ex_pc[2 +: PHT_IDX_W] ^ PHT_IDX_W'(ex_ghr);
    assign f_ctr  = pht[f_idx];

    // Only the index/tag slices of the PCs feed the tables.
    assign unused_bits = ^{f_pc, ex_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_idx <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    sweep_idx <= sweep_idx + PHT_IDX_W'(1);
                    if (sweep_idx == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Single PHT write port: the init sweep owns it until RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                pht[sweep_idx] <= WNT;
            end else if (ex_valid) begin
                pht[ex_idx] <= ctr_next(pht[ex_idx], ex_taken);
            end
        end
    end

    // Repair from the EX snapshot outranks the speculative fetch shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (run) begin
            if (mispredict) begin
                ghr <= {ex_ghr[GHR_W-2:0], ex_taken};
            end else if (f_valid && f_is_branch && !f_stall) begin
                ghr <= {ghr[GHR_W-2:0], pred_taken};
            end
        end
    end

    bp_btb #(
        .IDX_W (BTB_IDX_W),
        .TAG_W (TAG_W),
        .XLEN  (XLEN)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (f_pc[2 +: BTB_IDX_W]),
        .rd_tag    (f_pc[2 + BTB_IDX_W +: TAG_W]),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (run && ex_valid && ex_taken),
        .wr_idx    (ex_pc[2 +: BTB_IDX_W]),
        .wr_tag    (ex_pc[2 + BTB_IDX_W +: TAG_W]),
        .wr_target (ex_target)
    );

    assign pred_taken  = run && f_valid && f_is_branch && f_ctr[1] && btb_hit;
    assign pred_target = (run && btb_hit) ? btb_target : '0;
    assign pred_ghr    = ghr;

    assign mispredict  = run && ex_valid &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Directed bench for bp_gshare_btb: init sweep timing, learning, saturation,
// history repair/stall, BTB aliasing and redirect arithmetic.
module tb_bp_gshare_btb;
    localparam int XLEN  = 32;
    localparam int GHR_W = 10;
    localparam int SWEEP = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic             f_valid;
    logic             f_stall;
    logic [XLEN-1:0]  f_pc;
    logic             f_is_branch;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [GHR_W-1:0] pred_ghr;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic [GHR_W-1:0] ex_ghr;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;

    int n_chk = 0;
    int n_bad = 0;
    int cnt;

    always #5 clk = ~clk;

    bp_gshare_btb dut (
        .clk            (clk),
        .rst            (rst),
        .ready          (ready),
        .f_valid        (f_valid),
        .f_stall        (f_stall),
        .f_pc           (f_pc),
        .f_is_branch    (f_is_branch),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_ghr       (pred_ghr),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_ghr         (ex_ghr),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the GHR back to zero with fetches of a branch that never hits.
    task automatic flush_ghr();
        f_valid = 1'b1; f_is_branch = 1'b1; f_stall = 1'b0; f_pc = 32'h2000;
        repeat (GHR_W) tick();
        f_valid = 1'b0; f_is_branch = 1'b0;
    endtask

    task automatic count_sweep(input string tag);
        cnt = 0;
        while (!ready && cnt < SWEEP + 100) begin
            tick();
            cnt++;
        end
        chk(tag, cnt, SWEEP);
    endtask

    // One fetch of pc, then its resolution in EX, then a history flush.
    task automatic branch_iter(input string tag, input logic [31:0] pc, input logic tk,
                               input logic [31:0] tgt, input logic exp_pt,
                               input logic [31:0] exp_tgt, input logic exp_mp,
                               input logic [31:0] exp_rd);
        f_valid = 1'b1; f_is_branch = 1'b1; f_stall = 1'b0; f_pc = pc;
        #1;
        chk({tag, ".pred_taken"}, pred_taken, exp_pt);
        chk({tag, ".pred_target"}, pred_target, exp_tgt);
        chk({tag, ".pred_ghr"}, pred_ghr, 10'h000);
        tick();
        f_valid = 1'b0; f_is_branch = 1'b0;
        ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = exp_pt; ex_pred_target = exp_tgt; ex_ghr = 10'h000;
        #1;
        chk({tag, ".mispredict"}, mispredict, exp_mp);
        chk({tag, ".redirect"}, redirect_pc, exp_rd);
        tick();
        ex_valid = 1'b0;
        flush_ghr();
    endtask

    initial begin
        rst = 1'b1;
        f_valid = 1'b1; f_stall = 1'b0; f_pc = 32'h100; f_is_branch = 1'b1;
        ex_valid = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h80;
        ex_pred_taken = 1'b0; ex_pred_target = '0; ex_ghr = '0;

        // Reset state, with a mispredicting EX slot held active.
        repeat (3) tick();
        chk("rst.ready", ready, 1'b0);
        chk("rst.pred_taken", pred_taken, 1'b0);
        chk("rst.pred_target", pred_target, 32'h0);
        chk("rst.pred_ghr", pred_ghr, 10'h0);
        chk("rst.mispredict", mispredict, 1'b0);
        f_valid = 1'b0; f_is_branch = 1'b0; ex_valid = 1'b0;

        rst = 1'b0;
        count_sweep("sweep.len");
        chk("sweep.ready_hold", ready, 1'b1);

        // Reassert reset mid-sweep; EX traffic during INIT must be ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2000) tick();
        chk("mid.ready_low", ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_valid = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h80;
        ex_pred_taken = 1'b0; ex_pred_target = '0; ex_ghr = '0;
        #1;
        chk("init.mispredict", mispredict, 1'b0);
        ex_valid = 1'b0;
        count_sweep("mid.sweep_len");

        // Learning: branch @0x100 taken to 0x80, then saturation and one not-taken.
        branch_iter("b1", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,  1'b1, 32'h80);
        branch_iter("b2", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        branch_iter("b3", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        branch_iter("b4", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        branch_iter("b5", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        branch_iter("b6", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
        branch_iter("b7", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);

        // Combinational mispredict cases, withdrawn before the edge.
        ex_valid = 1'b1; ex_pc = 32'h500; ex_taken = 1'b1; ex_target = 32'h90;
        ex_pred_taken = 1'b1; ex_pred_target = 32'h80; ex_ghr = '0;
        #1;
        chk("tgt_miss.mispredict", mispredict, 1'b1);
        ex_taken = 1'b0; ex_pred_taken = 1'b0;
        #1;
        chk("nt_tgt_diff.mispredict", mispredict, 1'b0);
        chk("nt.redirect", redirect_pc, 32'h504);
        ex_pc = 32'hFFFF_FFFC; ex_pred_taken = 1'b1;
        #1;
        chk("wrap.mispredict", mispredict, 1'b1);
        chk("wrap.redirect", redirect_pc, 32'h0);
        ex_valid = 1'b0;
        #1;

        // Repair beats a same-cycle fetch shift.
        f_valid = 1'b1; f_is_branch = 1'b1; f_stall = 1'b0; f_pc = 32'h2000;
        ex_valid = 1'b1; ex_pc = 32'h3010; ex_taken = 1'b1; ex_target = 32'h400;
        ex_pred_taken = 1'b0; ex_pred_target = '0; ex_ghr = 10'h155;
        #1;
        chk("repair.mispredict", mispredict, 1'b1);
        tick();
        f_valid = 1'b0; f_is_branch = 1'b0; ex_valid = 1'b0;
        #1;
        chk("repair.ghr", pred_ghr, 10'h2AB);

        // Stalled fetches freeze history; one free fetch shifts in a 0.
        f_valid = 1'b1; f_is_branch = 1'b1; f_stall = 1'b1; f_pc = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("stall%0d.ghr", i), pred_ghr, 10'h2AB);
        end
        f_stall = 1'b0;
        tick();
        f_valid = 1'b0; f_is_branch = 1'b0;
        #1;
        chk("unstall.ghr", pred_ghr, 10'h156);

        // BTB alias: 0x200 shares index 0 with 0x100 but not its tag.
        f_pc = 32'h100;
        #1;
        chk("alias.own_target", pred_target, 32'h80);
        f_valid = 1'b1; f_is_branch = 1'b1; f_pc = 32'h200;
        #1;
        chk("alias.pred_taken", pred_taken, 1'b0);
        chk("alias.pred_target", pred_target, 32'h0);

        // Same-cycle write to the entry being read: old value now, new next cycle.
        ex_valid = 1'b1; ex_pc = 32'h200; ex_taken = 1'b1; ex_target = 32'h44;
        ex_pred_taken = 1'b0; ex_pred_target = '0; ex_ghr = '0;
        #1;
        chk("rw.old_target", pred_target, 32'h0);
        f_valid = 1'b0; f_is_branch = 1'b0;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("rw.new_target", pred_target, 32'h44);
        f_pc = 32'h100;
        #1;
        chk("rw.evicted", pred_target, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL timeout: got running want finished");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "timeout");
    end

endmodule
